pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. It drives the `enable` and clear inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard classes: load-use RAW hazards, control hazards from `jal_jalr` resolved in EX, and data-memory wait states. A watchdog escalates a hung memory access to a sticky fault.

## Interface
- `MEM_TIMEOUT`, default 64: max consecutive wait cycles on one memory access before FAULT (≥2).
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  5  destination of the EX instruction (ID/EX `rd_out`).
- `ex_wreg`  in  1  EX instruction writes the register file.
- `ex_rmm`  in  1  EX instruction is a load (ID/EX `RMM_out`).
- `ex_jump`  in  1  EX instruction is a taken `jal_jalr`.
- `mem_rd`  in  5  destination of the MEM instruction.
- `mem_wreg`  in  1  MEM instruction writes the register file.
- `mem_req`  in  1  MEM stage holds a load or store.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1 each  pipeline register enables.
- `if_id_flush`  out  1  clear IF/ID on the next edge.
- `id_ex_bubble`  out  1  clear ID/EX control fields (`wreg`, `WMM`, `RMM`, `MOA`, `jal_jalr`) on the next edge.
- `mem_err`  out  1  sticky memory-timeout fault.
- `stall_cnt`  out  `CNT_W`  saturating count of stalled cycles.

## Operation
- States: RUN, MEM_WAIT, FAULT. Register 0 is never a hazard (rd==0 ignored).
- `mem_stall` = `mem_req & ~mem_ready`. This applies in RUN and in MEM_WAIT.
- Priority order, evaluated combinationally each cycle:
  1. FAULT: all enables 0, flush 0, bubble 0.
  2. `mem_stall`: all five enables 0, flush 0, bubble 0. The whole pipe freezes.
  3. `ex_jump`: all enables 1, `if_id_flush`=1, `id_ex_bubble`=1. This kills the two younger instructions. A jump always beats load-use.
  4. Load-use (`ex_rmm & ex_wreg & ex_rd!=0 &` a used ID source equals `ex_rd`): `pc_en`=0, `if_id_en`=0, `id_ex_bubble`=1, other enables 1.
  5. Otherwise: all enables 1, flush 0, bubble 0.
- Transitions:
  - RUN→MEM_WAIT when `mem_stall`.
  - MEM_WAIT→RUN on the first cycle with `mem_ready`=1. That cycle's enables are already 1.
  - MEM_WAIT→FAULT when the wait counter reaches `MEM_TIMEOUT-1` with `mem_ready` still 0.
  - FAULT is left only by `rst`.
- Wait counter: `$clog2(MEM_TIMEOUT)` bits. Cleared in RUN; incremented each MEM_WAIT cycle.
- `stall_cnt` increments on every cycle where `pc_en`=0 and the state is not FAULT. It saturates at all-ones.

## Timing
- All outputs are combinational from the registered state plus current inputs. There is no added latency, and a hazard is suppressed in the same cycle it appears.
- During `rst`=1:
  - All enables are 1; flush, bubble, `mem_err` are 0.
  - On the edge: state←RUN, counters←0, `mem_err`←0.
- Load-use costs exactly one bubble. On the next cycle the load sits in MEM and the condition clears.
- A jump costs two flushed slots.
- `mem_err` rises on the edge entering FAULT and holds until reset.
- `rst` mid-MEM_WAIT aborts the wait. There is no residual stall.

## Configuration
- `HAZARD_FWD_EN` defined: a forwarding network exists, and only load-use (rule 4) stalls.
- Undefined: rule 4 is widened to any RAW match against `ex_wreg/ex_rd` or `mem_wreg/mem_rd`, regardless of `ex_rmm`. The stall holds until the writer retires past MEM. WB-stage hazards are covered by the register file's write-before-read.

## Test plan
- Load-use: `ex_rmm=1`, `ex_wreg=1`, `ex_rd=5`, `id_rs2=5`, `id_use_rs2=1` → one cycle with `pc_en=0`, `if_id_en=0`, `id_ex_bubble=1`, `stall_cnt` 0→1. With `ex_rd=0` → no stall.
- Jump plus simultaneous load-use match → `if_id_flush=1`, `id_ex_bubble=1`, `pc_en=1`.
- Memory wait: `mem_req=1`, `mem_ready=0` for 3 cycles then 1 → enables 0 for 3 cycles, 1 on the ready cycle, state back to RUN, `stall_cnt`=3.
- Timeout with `MEM_TIMEOUT=4`, `mem_ready` held 0 → `mem_err=1` after 5 cycles and all enables 0. A later `mem_ready` has no effect; `rst` clears it.
- Without `HAZARD_FWD_EN`: ALU writer `mem_rd=7`, `id_rs1=7` → stall. With the macro defined → no stall.
- `stall_cnt` saturation with `CNT_W=4` → holds at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status into the controller, register enables and
// fault/performance status back out to the datapath.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_wreg;
  logic             ex_rmm;
  logic             ex_jump;
  logic [4:0]       mem_rd;
  logic             mem_wreg;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_wreg, ex_rmm, ex_jump,
    output mem_rd, mem_wreg, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_bubble, mem_err, stall_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_wreg, ex_rmm, ex_jump,
    input  mem_rd, mem_wreg, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_bubble, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use, jump and memory-wait hazards
// with a memory watchdog. Define HAZARD_FWD_EN when the core has a forwarding network.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FAULT    = 2'd2
  } state_t;

  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_mem_stall;
  logic w_ex_hit;
  logic w_raw_hazard;
  logic w_pc_en;
  logic w_if_id_en;
  logic w_id_ex_en;
  logic w_ex_mem_en;
  logic w_mem_wb_en;
  logic w_if_id_flush;
  logic w_id_ex_bubble;

  function automatic logic src_match(
    input logic [4:0] rd,
    input logic       wr,
    input logic [4:0] rs1,
    input logic       use1,
    input logic [4:0] rs2,
    input logic       use2
  );
    return wr && (rd != 5'd0) && ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  assign w_mem_stall = hz.mem_req & ~hz.mem_ready;
  assign w_ex_hit    = src_match(hz.ex_rd, hz.ex_wreg, hz.id_rs1, hz.id_use_rs1,
                                 hz.id_rs2, hz.id_use_rs2);

`ifdef HAZARD_FWD_EN
  // Forwarding covers every RAW except a load whose data is not back until after MEM.
  assign w_raw_hazard = w_ex_hit & hz.ex_rmm;
`else
  logic w_mem_hit;
  logic w_ex_load_hit;
  logic w_ex_alu_hit;

  // No forwarding: any writer still in EX or MEM blocks ID until it reaches WB.
  assign w_mem_hit     = src_match(hz.mem_rd, hz.mem_wreg, hz.id_rs1, hz.id_use_rs1,
                                   hz.id_rs2, hz.id_use_rs2);
  assign w_ex_load_hit = w_ex_hit & hz.ex_rmm;
  assign w_ex_alu_hit  = w_ex_hit & ~hz.ex_rmm;
  assign w_raw_hazard  = w_ex_load_hit | w_ex_alu_hit | w_mem_hit;
`endif

  always_comb begin
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_id_ex_en     = 1'b1;
    w_ex_mem_en    = 1'b1;
    w_mem_wb_en    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;

    if (!rst) begin
      if ((r_state == S_FAULT) || w_mem_stall) begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_id_ex_en  = 1'b0;
        w_ex_mem_en = 1'b0;
        w_mem_wb_en = 1'b0;
      end else if (hz.ex_jump) begin
        w_if_id_flush  = 1'b1;
        w_id_ex_bubble = 1'b1;
      end else if (w_raw_hazard) begin
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_id_ex_bubble = 1'b1;
      end
    end

    case (r_state)
      S_RUN: begin
        w_wait_cnt_nxt = '0;
        if (w_mem_stall) w_state_nxt = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (!w_mem_stall) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_state_nxt == S_FAULT) r_mem_err <= 1'b1;
      if (!w_pc_en && (r_state != S_FAULT)) r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign hz.pc_en        = w_pc_en;
  assign hz.if_id_en     = w_if_id_en;
  assign hz.id_ex_en     = w_id_ex_en;
  assign hz.ex_mem_en    = w_ex_mem_en;
  assign hz.mem_wb_en    = w_mem_wb_en;
  assign hz.if_id_flush  = w_if_id_flush;
  assign hz.id_ex_bubble = w_id_ex_bubble;
  assign hz.mem_err      = r_mem_err & ~rst;
  assign hz.stall_cnt    = r_stall_cnt;

endmodule
